// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin conditioning, frame FSM and scan-code decode into the 11-bit ps2_key event word.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of keys that are already held.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and parity, then back to IDLE
module ps2_key_decoder #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 is the clock pin, index 1 the data pin
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          filt_clk_d;
  logic          sample, data_bit;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit, stop_ok, stop_bad;
  logic          byte_rdy, byte_bad;

  logic          ext, brk;
  logic [2:0]    skip;
  logic          emit, suppress;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_clk_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1      <= {ps2_data, ps2_clk};
      sync2      <= sync1;
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign sample      = filt_clk_d & ~filt[0];
  assign data_bit    = filt[1];
  // a clock fall in the expiry cycle wins over the timeout
  assign timeout_hit = (state_q != IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (sample) begin
      case (state_q)
        IDLE:    if (!data_bit) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (data_bit && (^{shreg, par_q})) stop_ok = 1'b1;
          else stop_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      to_cnt   <= '0;
      byte_rdy <= 1'b0;
      byte_bad <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_rdy <= stop_ok;
      byte_bad <= stop_bad;
      if (state_q == IDLE || sample) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      if (sample) begin
        case (state_q)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_q <= data_bit;
          default: ;
        endcase
      end
    end
  end

  // a byte that survives prefix/skip/device-response filtering becomes a key event
  assign emit = byte_rdy && (skip == 3'd0)
             && !(shreg inside {8'hE0, 8'hE1, 8'hF0})
             && !(!ext && !brk && (shreg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}));

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] held;
  assign suppress = !brk && held[{ext, shreg}];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) held <= '0;
    else if (emit && !suppress) held[{ext, shreg}] <= !brk;
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ps2_key   <= '0;
      frame_err <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip      <= '0;
    end else begin
      frame_err <= byte_bad | timeout_hit;
      if (byte_bad || timeout_hit) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (byte_rdy) begin
        if (skip != 3'd0) skip <= skip - 3'd1;
        else if (shreg == 8'hE1) skip <= 3'd7;
        else if (shreg == 8'hE0) ext <= 1'b1;
        else if (shreg == 8'hF0) brk <= 1'b1;
        else if (emit) begin
          if (!suppress) ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized bench for ps2_key_decoder; the reference model applies the scan-code rules byte by byte.
module tb_ps2_key_decoder;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 20000;
  localparam int HALF        = 15;
  localparam int GAP         = 30;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  logic last_t = 1'b0;

  // reference model state
  logic [10:0] m_key;
  bit          m_ext, m_brk;
  int          m_skip;
  int          m_events, m_errs;
  bit          held_m [512];

  ps2_key_decoder #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (reset_n && ps2_key[10] !== last_t) ev_cnt++;
    last_t = ps2_key[10];
    if (reset_n && frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_sys);
    reset_n = 1'b0;
    repeat (4) @(posedge clk_sys);
    reset_n = 1'b1;
    m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0;
    foreach (held_m[i]) held_m[i] = 0;
    @(posedge clk_sys);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input bit par_ok, input bit stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(par_ok ? ~^c : ^c);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk_sys);
  endtask

  task automatic model_byte(input logic [7:0] c, input bit good);
    bit sup;
    if (!good) begin
      m_errs++; m_ext = 0; m_brk = 0; m_skip = 0;
      return;
    end
    if (m_skip > 0) m_skip--;
    else if (c == 8'hE1) m_skip = 7;
    else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else if (!m_ext && !m_brk && (c inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
    end else begin
      sup = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      sup = !m_brk && held_m[{m_ext, c}];
      if (!sup) held_m[{m_ext, c}] = !m_brk;
`endif
      if (!sup) begin
        m_key = {~m_key[10], ~m_brk, m_ext, c};
        m_events++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_good(input logic [7:0] c);
    send_frame(c, 1'b1, 1'b1);
  endtask

  initial begin
    int ev0, er0, n;
    logic [7:0] pause_seq [9];
    logic [7:0] specials [8];
    logic [7:0] c;
    int kind;

    repeat (5) @(posedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("reset_key", 32'(ps2_key), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);

    // basic frame
    ev0 = ev_cnt; er0 = err_cnt;
    send_good(8'h29);
    chk("key_29", 32'(ps2_key), 32'h629);
    chk("ev_29", 32'(ev_cnt - ev0), 32'd1);
    chk("err_29", 32'(err_cnt - er0), 32'd0);

    // extended make and break
    do_reset();
    ev0 = ev_cnt;
    send_good(8'hE0); send_good(8'h75);
    chk("key_e075", 32'(ps2_key), 32'h775);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    chk("key_e0f075", 32'(ps2_key), 32'h175);
    chk("ev_ext", 32'(ev_cnt - ev0), 32'd2);

    // parity error then valid break
    ev0 = ev_cnt; er0 = err_cnt;
    send_frame(8'h14, 1'b0, 1'b1);
    chk("err_par", 32'(err_cnt - er0), 32'd1);
    chk("key_par_hold", 32'(ps2_key), 32'h175);
    send_good(8'hF0); send_good(8'h14);
    chk("key_f014", 32'(ps2_key), 32'h414);
    chk("ev_par", 32'(ev_cnt - ev0), 32'd1);

    // stop-bit error
    er0 = err_cnt;
    send_frame(8'h33, 1'b1, 1'b0);
    chk("err_stop", 32'(err_cnt - er0), 32'd1);
    chk("key_stop_hold", 32'(ps2_key), 32'h414);

    // timeout after 4 data bits
    do_reset();
    er0 = err_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b0;
    n = 0;
    while (n < TIMEOUT_CYC + 40) begin
      @(negedge clk_sys);
      if (frame_err === 1'b1) break;
      if (n == HALF) ps2_clk = 1'b1;
      n++;
    end
    ps2_clk = 1'b1;
    vectors++;
    assert (n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 20) else begin
      miscompares++;
      $error("FAIL timeout_lat observed=%0d expected=%0d..%0d", n, TIMEOUT_CYC, TIMEOUT_CYC + 20);
    end
    repeat (GAP) @(posedge clk_sys);
    chk("err_timeout", 32'(err_cnt - er0), 32'd1);
    chk("key_timeout_hold", 32'(ps2_key), 32'h0);
    send_good(8'h1C);
    chk("key_after_to", 32'(ps2_key), 32'h61C);

    // pause sequence and device response
    do_reset();
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h05};
    ev0 = ev_cnt;
    foreach (pause_seq[i]) send_good(pause_seq[i]);
    chk("key_pause", 32'(ps2_key), 32'h605);
    chk("ev_pause", 32'(ev_cnt - ev0), 32'd1);
    send_good(8'hAA);
    chk("key_aa", 32'(ps2_key), 32'h605);
    chk("ev_aa", 32'(ev_cnt - ev0), 32'd1);

    // typematic repeats
    do_reset();
    ev0 = ev_cnt;
    send_good(8'h1C);
    chk("key_tm1", 32'(ps2_key), 32'h61C);
    send_good(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("key_tm2", 32'(ps2_key), 32'h61C);
`else
    chk("key_tm2", 32'(ps2_key), 32'h21C);
`endif
    send_good(8'h1C); send_good(8'hF0); send_good(8'h1C);
    chk("key_tm_brk", 32'(ps2_key), 32'h01C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("ev_tm", 32'(ev_cnt - ev0), 32'd2);
`else
    chk("ev_tm", 32'(ev_cnt - ev0), 32'd4);
`endif

    // reset mid-frame
    do_reset();
    send_good(8'h29);
    er0 = err_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    do_reset();
    repeat (GAP) @(posedge clk_sys);
    chk("key_midrst", 32'(ps2_key), 32'h0);
    chk("err_midrst", 32'(err_cnt - er0), 32'd0);
    send_good(8'h29);
    chk("key_after_rst", 32'(ps2_key), 32'h629);

    // randomized frames against the reference model
    do_reset();
    specials = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFA, 8'hFF, 8'hEE};
    m_events = 0; m_errs = 0;
    ev0 = ev_cnt; er0 = err_cnt;
    for (int k = 0; k < 60; k++) begin
      c = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame(c, kind != 0, kind != 1);
      model_byte(c, kind >= 2);
      chk($sformatf("rnd_key[%0d]", k), 32'(ps2_key), 32'(m_key));
      chk($sformatf("rnd_ev[%0d]", k), 32'(ev_cnt - ev0), 32'(m_events));
      chk($sformatf("rnd_err[%0d]", k), 32'(err_cnt - er0), 32'(m_errs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
